audio_info_frame_builder: RTL and testbench

Runtime-programmable InfoFrame generator for the HDMI data-island path. Software or control logic writes payload bytes PB1..PB(LENGTH) into a staging buffer and commits. The block computes the checksum sequentially, one byte per cycle, then swaps header and subpackets atomically into output registers on a packet-boundary strobe from the packet scheduler, so a packet is never assembled from a half-updated frame. It generalises the fixed-parameter audio InfoFrame to any InfoFrame type and length, with live updates and a correct two's-complement checksum.

---
 rtl/audio_info_frame_builder.sv | 143 ++++++++++++++
 tb/tb_audio_info_frame_builder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_info_frame_builder.sv
// rtl/audio_info_frame_builder.sv - InfoFrame builder with staged payload, sequential checksum and atomic swap
module audio_info_frame_builder #(
    parameter logic [6:0] TYPE    = 7'd4,
    parameter logic [7:0] VERSION = 8'd1,
    parameter logic [4:0] LENGTH  = 5'd10
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             commit,
    input  logic             swap,
    output logic             ready,
    output logic             pending,
    output logic             frame_valid,
    output logic [23:0]      header,
    output logic [3:0][55:0] sub
);

    localparam logic [23:0] HDR   = {3'b000, LENGTH, VERSION, 1'b1, TYPE};
    localparam logic [7:0]  H_SUM = HDR[7:0] + HDR[15:8] + HDR[23:16];

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_PENDING
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  checksum_q, checksum_d;
    logic        valid_q, valid_d;
    logic [7:0]  staging_q [1:27];
    logic [7:0]  staging_d [1:27];
    logic [7:0]  image_q [0:27];
    logic [7:0]  image_d [0:27];

    logic        wr_accept;
    logic [7:0]  byte_sel;
    logic [7:0]  sum_next;

    assign wr_accept = wr_en && (state_q == S_IDLE) && (wr_addr != 5'd0) && (wr_addr <= LENGTH);

    always_comb begin
        byte_sel = 8'h00;
        for (int i = 1; i <= 27; i++) begin
            if (idx_q == 5'(i)) begin
                byte_sel = staging_q[i];
            end
        end
    end

    assign sum_next = acc_q + byte_sel;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        checksum_d = checksum_q;
        valid_d    = valid_q;
        staging_d  = staging_q;
        image_d    = image_q;

        case (state_q)
            S_IDLE: begin
                // A write in the commit cycle lands before SUM starts reading.
                for (int i = 1; i <= 27; i++) begin
                    if (wr_accept && (wr_addr == 5'(i))) begin
                        staging_d[i] = wr_data;
                    end
                end
                if (commit) begin
                    acc_d   = H_SUM;
                    idx_d   = 5'd1;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                acc_d = sum_next;
                idx_d = idx_q + 5'd1;
                if (idx_q == LENGTH) begin
                    checksum_d = 8'h00 - sum_next;
                    state_d    = S_PENDING;
                end
            end
            S_PENDING: begin
                if (swap) begin
                    image_d[0] = checksum_q;
                    for (int i = 1; i <= 27; i++) begin
                        image_d[i] = (5'(i) <= LENGTH) ? staging_q[i] : 8'h00;
                    end
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= 8'h00;
            idx_q      <= 5'd0;
            checksum_q <= 8'h00;
            valid_q    <= 1'b0;
            for (int i = 1; i <= 27; i++) begin
                staging_q[i] <= 8'h00;
            end
            for (int i = 0; i <= 27; i++) begin
                image_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            checksum_q <= checksum_d;
            valid_q    <= valid_d;
            staging_q  <= staging_d;
            image_q    <= image_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign pending     = (state_q == S_PENDING);
    assign frame_valid = valid_q;
    assign header      = HDR;

    // Subpacket i carries PB(7i)..PB(7i+6), lowest byte index in the lowest bits.
    always_comb begin
        sub = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 7; j++) begin
                sub[i][8*j +: 8] = image_q[7*i + j];
            end
        end
    end

endmodule

// File: tb/tb_audio_info_frame_builder.sv
// tb/tb_audio_info_frame_builder.sv - self-checking bench for audio_info_frame_builder
module tb_audio_info_frame_builder;

    localparam int NI = 3;
    localparam int LENS [NI] = '{10, 1, 27};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             wr_en   [NI];
    logic [4:0]       wr_addr [NI];
    logic [7:0]       wr_data [NI];
    logic             commit  [NI];
    logic             swap    [NI];
    logic             ready   [NI];
    logic             pending [NI];
    logic             frame_valid [NI];
    logic [23:0]      header  [NI];
    logic [3:0][55:0] sub     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        audio_info_frame_builder #(
            .TYPE    (7'd4),
            .VERSION (8'd1),
            .LENGTH  (5'(LENS[g]))
        ) dut (
            .clk_pixel   (clk),
            .reset       (reset),
            .wr_en       (wr_en[g]),
            .wr_addr     (wr_addr[g]),
            .wr_data     (wr_data[g]),
            .commit      (commit[g]),
            .swap        (swap[g]),
            .ready       (ready[g]),
            .pending     (pending[g]),
            .frame_valid (frame_valid[g]),
            .header      (header[g]),
            .sub         (sub[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int stage_m [NI][28];
    int img_m   [NI][28];
    int chk_m   [NI];
    int pend_at [NI];
    bit valid_m [NI];

    typedef struct {
        int          n;
        logic [4:0]  a0;
        logic [7:0]  d0;
        logic [4:0]  a1;
        logic [7:0]  d1;
        logic [55:0] sub0;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int hdr_sum(input int k);
        return (8'h84 + 8'h01 + LENS[k]) % 256;
    endfunction

    function automatic logic [223:0] exp_sub(input int k);
        logic [223:0] r;
        for (int i = 0; i < 28; i++) r[8*i +: 8] = 8'(img_m[k][i]);
        return r;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                for (int i = 0; i < 28; i++) begin
                    stage_m[k][i] = 0;
                    img_m[k][i]   = 0;
                end
                pend_at[k] = -1;
                valid_m[k] = 0;
                chk_m[k]   = 0;
            end else begin
                bit idle;
                idle = (pend_at[k] < 0);
                if (idle && wr_en[k] && wr_addr[k] >= 1 && int'(wr_addr[k]) <= LENS[k])
                    stage_m[k][wr_addr[k]] = wr_data[k];
                if (!idle && cyc >= pend_at[k] && swap[k]) begin
                    img_m[k][0] = chk_m[k];
                    for (int i = 1; i <= LENS[k]; i++) img_m[k][i] = stage_m[k][i];
                    valid_m[k] = 1;
                    pend_at[k] = -1;
                end else if (idle && commit[k]) begin
                    int s;
                    s = hdr_sum(k);
                    for (int i = 1; i <= LENS[k]; i++) s += stage_m[k][i];
                    chk_m[k]   = (256 - (s % 256)) % 256;
                    pend_at[k] = cyc + LENS[k] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("ready[%0d]@%0d", k, cyc), ready[k], pend_at[k] < 0);
            chk($sformatf("pending[%0d]@%0d", k, cyc), pending[k], pend_at[k] >= 0 && cyc >= pend_at[k]);
            chk($sformatf("frame_valid[%0d]@%0d", k, cyc), frame_valid[k], valid_m[k]);
            chk($sformatf("header[%0d]@%0d", k, cyc), header[k], 24'h000184 | (24'(LENS[k]) << 16));
            chk($sformatf("sub[%0d]@%0d", k, cyc), sub[k], exp_sub(k));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            wr_en[k]  = 1'b0;
            commit[k] = 1'b0;
            swap[k]   = 1'b0;
        end
        check_all();
    endtask

    task automatic write_pb(input int k, input logic [4:0] a, input logic [7:0] d);
        wr_en[k] = 1'b1; wr_addr[k] = a; wr_data[k] = d;
        tick();
    endtask

    task automatic commit_and_swap(input int k, output int lat);
        commit[k] = 1'b1;
        tick();
        lat = 1;
        while (!pending[k] && lat < 64) begin
            tick();
            lat++;
        end
        swap[k] = 1'b1;
        tick();
    endtask

    task automatic check_invariant(input int k, input string name);
        int s;
        s = 8'h84 + 8'h01 + LENS[k];
        for (int i = 0; i < 28; i++) s += int'(sub[k][i / 7][8*(i % 7) +: 8]);
        chk(name, 32'(s % 256), 32'd0);
    endtask

    initial begin
        int lat;
        logic [223:0] snap;

        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            wr_en[k] = 0; wr_addr[k] = 0; wr_data[k] = 0; commit[k] = 0; swap[k] = 0;
            pend_at[k] = -1; valid_m[k] = 0; chk_m[k] = 0;
            for (int i = 0; i < 28; i++) begin stage_m[k][i] = 0; img_m[k][i] = 0; end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();

        chk("reset_header", header[0], 24'h0A0184);
        chk("reset_sub", sub[0], 224'h0);
        chk("reset_frame_valid", frame_valid[0], 1'b0);
        chk("reset_ready", ready[0], 1'b1);

        vecs[0] = '{1, 5'd1,  8'h01, 5'd0, 8'h00, 56'h00000000000170};
        vecs[1] = '{2, 5'd1,  8'h07, 5'd4, 8'h13, 56'h00001300000757};
        vecs[2] = '{2, 5'd12, 8'hFF, 5'd0, 8'hAA, 56'h00001300000757};

        for (int v = 0; v < 3; v++) begin
            write_pb(0, vecs[v].a0, vecs[v].d0);
            if (vecs[v].n > 1) write_pb(0, vecs[v].a1, vecs[v].d1);
            commit_and_swap(0, lat);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd11);
            chk($sformatf("vec%0d_sub0", v), sub[0][0], vecs[v].sub0);
            chk($sformatf("vec%0d_sub123", v), {sub[0][3], sub[0][2], sub[0][1]}, 168'h0);
            chk($sformatf("vec%0d_valid", v), frame_valid[0], 1'b1);
            check_invariant(0, $sformatf("vec%0d_invariant", v));
        end

        // Writes and a swap during SUM are dropped; the earlier image holds until a real swap.
        snap = sub[0];
        commit[0] = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) begin wr_en[0] = 1'b1; wr_addr[0] = 5'd2; wr_data[0] = 8'h55; end
            if (c == 5) swap[0] = 1'b1;
            chk($sformatf("sum_no_pending_c%0d", c), pending[0], 1'b0);
            tick();
        end
        chk("sum_pending_at_11", pending[0], 1'b1);
        tick();
        tick();
        chk("pending_holds_outputs", sub[0], snap);
        swap[0] = 1'b1;
        tick();
        chk("dropped_sub0", sub[0][0], 56'h00001300000757);
        chk("dropped_sub1", sub[0][1], 56'h0);

        // Extreme lengths with random payloads.
        for (int k = 1; k < NI; k++) begin
            for (int rep = 0; rep < 3; rep++) begin
                for (int a = 1; a <= LENS[k]; a++) write_pb(k, 5'(a), 8'($urandom));
                write_pb(k, 5'($urandom_range(28, 31)), 8'($urandom));
                commit_and_swap(k, lat);
                chk($sformatf("sweep%0d_%0d_latency", LENS[k], rep), 32'(lat), 32'(LENS[k] + 1));
                check_invariant(k, $sformatf("sweep%0d_%0d_invariant", LENS[k], rep));
                for (int i = LENS[k] + 1; i < 28; i++)
                    chk($sformatf("sweep%0d_%0d_zero_pb%0d", LENS[k], rep, i),
                        sub[k][i / 7][8*(i % 7) +: 8], 8'h00);
            end
        end

        // Random traffic on all instances at once.
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NI; k++) begin
                wr_en[k]   = ($urandom_range(0, 9) < 4);
                wr_addr[k] = 5'($urandom);
                wr_data[k] = 8'($urandom);
                commit[k]  = ($urandom_range(0, 9) == 0);
                swap[k]    = ($urandom_range(0, 4) == 0);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        // Reset while a different frame is armed.
        write_pb(0, 5'd3, 8'h99);
        commit[0] = 1'b1;
        tick();
        lat = 1;
        while (!pending[0] && lat < 64) begin tick(); lat++; end
        chk("rst_arm_latency", 32'(lat), 32'd11);
        reset = 1'b1;
        tick();
        chk("rst_sub", sub[0], 224'h0);
        chk("rst_frame_valid", frame_valid[0], 1'b0);
        chk("rst_ready", ready[0], 1'b1);
        chk("rst_pending", pending[0], 1'b0);
        swap[0] = 1'b1;
        tick();
        tick();
        chk("rst_swap_sub", sub[0], 224'h0);
        chk("rst_swap_valid", frame_valid[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
